movegen_move_sequencer: RTL and testbench

- Parametrised successor to the board's piece-stack/iterator front end.
- Builds per-colour piece stacks and a 64-square piece shadow from the serial position bus.
- On `start`, walks every piece of the side to play and asks the square array for that piece's destination mask over a request/response handshake.
- Arbitrates the mask into individual 20-bit UCI moves, expanding pawn promotions, and streams them out with valid/ready backpressure and sop/eop framing.

---
 rtl/movegen_pkg.sv | 37 +++
 rtl/movegen_colour_stack.sv | 55 +++++
 rtl/movegen_move_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_movegen_move_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/movegen_pkg.sv
// movegen_pkg: piece codes, move word layout, stack entry and
// sequencer state encodings shared by the move sequencer.
package movegen_pkg;

    localparam logic [2:0] PC_NONE   = 3'd0;
    localparam logic [2:0] PC_KING   = 3'd1;
    localparam logic [2:0] PC_QUEEN  = 3'd2;
    localparam logic [2:0] PC_ROOK   = 3'd3;
    localparam logic [2:0] PC_BISHOP = 3'd4;
    localparam logic [2:0] PC_KNIGHT = 3'd5;
    localparam logic [2:0] PC_PAWN   = 3'd6;

    typedef struct packed {
        logic [1:0] promote;
        logic [2:0] piece;
        logic [2:0] from_r;
        logic [2:0] from_f;
        logic [2:0] takes;
        logic [2:0] to_r;
        logic [2:0] to_f;
    } uci_move_t;

    typedef struct packed {
        logic [2:0] piece;
        logic [2:0] rank;
        logic [2:0] file;
    } stack_entry_t;

    typedef logic [2:0] seq_state_t;

    localparam seq_state_t ST_IDLE = 3'd0;
    localparam seq_state_t ST_REQ  = 3'd1;
    localparam seq_state_t ST_WAIT = 3'd2;
    localparam seq_state_t ST_EMIT = 3'd3;
    localparam seq_state_t ST_TERM = 3'd4;

endpackage

// File: rtl/movegen_colour_stack.sv
// movegen_colour_stack: arrival-ordered piece list for one colour with
// parallel read-out; pushes beyond DEPTH are dropped and flagged.
module movegen_colour_stack
    import movegen_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  stack_entry_t             push_data,
    output stack_entry_t [DEPTH-1:0] entries,
    output logic [5:0]               count,
    output logic                     overflow
);

    stack_entry_t [DEPTH-1:0] ent_q, ent_d;
    logic [5:0]               cnt_q, cnt_d, base;
    logic                     ovf_q, ovf_d;

    // A clearing beat may also push, so it lands in slot 0.
    always_comb begin
        ent_d = ent_q;
        base  = clear ? 6'd0 : cnt_q;
        cnt_d = base;
        ovf_d = clear ? 1'b0 : ovf_q;
        if (push) begin
            if (base == 6'(DEPTH)) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = base + 6'd1;
                for (int i = 0; i < DEPTH; i++)
                    if (base == 6'(i)) ent_d[i] = push_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            ent_q <= ent_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign entries  = ent_q;
    assign count    = cnt_q;
    assign overflow = ovf_q;

endmodule

// File: rtl/movegen_move_sequencer.sv
// movegen_move_sequencer: loads piece stacks from the position bus, walks the
// side to play, fetches destination masks and streams framed UCI move words.
module movegen_move_sequencer
    import movegen_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int PROMO_EXPAND = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_pos_valid,
    input  logic [3:0]  in_pos_data,
    input  logic        in_pos_sop,
    input  logic        in_pos_eop,
    input  logic        in_wtp,
    input  logic        start,
    output logic        busy,
    output logic        overflow,
    output logic        sq_from_valid,
    output logic [5:0]  sq_from,
    input  logic        sq_to_valid,
    input  logic [63:0] sq_to_mask,
    input  logic        o_uci_ready,
    output logic        o_uci_valid,
    output logic [19:0] o_uci_data,
    output logic        o_uci_sop,
    output logic        o_uci_eop
);

    seq_state_t               state_q, state_d;
    logic [5:0]               k_q, k_d, ld_k;
    logic [2:0]               ld_rank, ld_file;
    logic                     load, push_w, push_b, ovf_w, ovf_b;
    logic [63:0][2:0]         shadow_q, shadow_d;
    stack_entry_t             ld_ent, head;
    stack_entry_t [DEPTH-1:0] w_ent, b_ent, it_q, it_d;
    logic [5:0]               w_cnt, b_cnt, it_cnt_q, it_cnt_d;
    logic [5:0]               it_idx_q, it_idx_d, sel;
    logic [63:0]              mask_q, mask_d;
    logic [1:0]               promo_q, promo_d;
    logic                     wtp_q, wtp_d, sop_pend_q, sop_pend_d;
    logic                     promo_more;
    uci_move_t                word;

    assign load    = in_pos_valid && (state_q == ST_IDLE);
    assign ld_k    = in_pos_sop ? 6'd0 : k_q;
    assign ld_rank = 3'd7 - ld_k[5:3];
    assign ld_file = ld_k[2:0];
    assign ld_ent  = '{piece: in_pos_data[2:0], rank: ld_rank, file: ld_file};
    assign push_w  = load && (in_pos_data[2:0] != PC_NONE) && in_pos_data[3];
    assign push_b  = load && (in_pos_data[2:0] != PC_NONE) && !in_pos_data[3];

    always_comb begin
        k_d      = k_q;
        shadow_d = shadow_q;
        if (load) begin
            k_d = (in_pos_eop || ld_k == 6'd63) ? 6'd63 : ld_k + 6'd1;
            if (in_pos_sop) shadow_d = '0;
            shadow_d[{ld_rank, ld_file}] = in_pos_data[2:0];
        end
    end

    movegen_colour_stack #(.DEPTH(DEPTH)) u_white (
        .clk(clk), .rst_n(rst_n), .clear(load && in_pos_sop),
        .push(push_w), .push_data(ld_ent),
        .entries(w_ent), .count(w_cnt), .overflow(ovf_w)
    );

    movegen_colour_stack #(.DEPTH(DEPTH)) u_black (
        .clk(clk), .rst_n(rst_n), .clear(load && in_pos_sop),
        .push(push_b), .push_data(ld_ent),
        .entries(b_ent), .count(b_cnt), .overflow(ovf_b)
    );

    always_comb begin
        head = '0;
        for (int i = 0; i < DEPTH; i++)
            if (it_idx_q == 6'(i)) head = it_q[i];
    end

    // Fixed priority: lowest set destination square wins.
    always_comb begin
        sel = '0;
        for (int i = 63; i >= 0; i--)
            if (mask_q[i]) sel = 6'(i);
    end

    assign promo_more = (PROMO_EXPAND != 0) && (head.piece == PC_PAWN) &&
                        (sel[5:3] == (wtp_q ? 3'd7 : 3'd0)) && (promo_q != 2'd3);

    always_comb begin
        state_d       = state_q;
        it_d          = it_q;
        it_cnt_d      = it_cnt_q;
        it_idx_d      = it_idx_q;
        mask_d        = mask_q;
        promo_d       = promo_q;
        wtp_d         = wtp_q;
        sop_pend_d    = sop_pend_q;
        sq_from_valid = 1'b0;
        sq_from       = '0;
        o_uci_valid   = 1'b0;
        o_uci_eop     = 1'b0;
        word          = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    wtp_d      = in_wtp;
                    it_d       = in_wtp ? w_ent : b_ent;
                    it_cnt_d   = in_wtp ? w_cnt : b_cnt;
                    it_idx_d   = '0;
                    promo_d    = '0;
                    sop_pend_d = 1'b1;
                    state_d    = ST_REQ;
                end
            end
            ST_REQ: begin
                if (it_idx_q == it_cnt_q) begin
                    state_d = ST_TERM;
                end else begin
                    sq_from_valid = 1'b1;
                    sq_from       = {head.rank, head.file};
                    state_d       = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (sq_to_valid) begin
                    mask_d  = sq_to_mask;
                    promo_d = '0;
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (mask_q == '0) begin
                    it_idx_d = it_idx_q + 6'd1;
                    state_d  = ST_REQ;
                end else begin
                    o_uci_valid = 1'b1;
                    word = '{promote: promo_q, piece: head.piece,
                             from_r: head.rank, from_f: head.file,
                             takes: shadow_q[sel], to_r: sel[5:3],
                             to_f: sel[2:0]};
                    if (o_uci_ready) begin
                        sop_pend_d = 1'b0;
                        if (promo_more) begin
                            promo_d = promo_q + 2'd1;
                        end else begin
                            promo_d = '0;
                            mask_d  = mask_q & ~(64'd1 << sel);
                        end
                    end
                end
            end
            ST_TERM: begin
                o_uci_valid = 1'b1;
                o_uci_eop   = 1'b1;
                if (o_uci_ready) begin
                    sop_pend_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            k_q        <= '0;
            shadow_q   <= '0;
            it_q       <= '0;
            it_cnt_q   <= '0;
            it_idx_q   <= '0;
            mask_q     <= '0;
            promo_q    <= '0;
            wtp_q      <= 1'b0;
            sop_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            shadow_q   <= shadow_d;
            it_q       <= it_d;
            it_cnt_q   <= it_cnt_d;
            it_idx_q   <= it_idx_d;
            mask_q     <= mask_d;
            promo_q    <= promo_d;
            wtp_q      <= wtp_d;
            sop_pend_q <= sop_pend_d;
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign overflow   = ovf_w | ovf_b;
    assign o_uci_data = word;
    assign o_uci_sop  = o_uci_valid && sop_pend_q;

endmodule

// File: tb/tb_movegen_move_sequencer.sv
// tb_movegen_move_sequencer: directed and random frames checked against a
// board-level model of the expected move stream.
module tb_movegen_move_sequencer;

    localparam int TB_DEPTH = 4;
    localparam bit TB_PX    = 1'b1;

    logic        clk, rst_n;
    logic        in_pos_valid, in_pos_sop, in_pos_eop, in_wtp, start;
    logic [3:0]  in_pos_data;
    logic        busy, overflow, sq_from_valid, sq_to_valid;
    logic [5:0]  sq_from;
    logic [63:0] sq_to_mask;
    logic        o_uci_ready, o_uci_valid, o_uci_sop, o_uci_eop;
    logic [19:0] o_uci_data;

    movegen_move_sequencer #(.DEPTH(TB_DEPTH), .PROMO_EXPAND(TB_PX)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_pos_valid(in_pos_valid), .in_pos_data(in_pos_data),
        .in_pos_sop(in_pos_sop), .in_pos_eop(in_pos_eop),
        .in_wtp(in_wtp), .start(start), .busy(busy), .overflow(overflow),
        .sq_from_valid(sq_from_valid), .sq_from(sq_from),
        .sq_to_valid(sq_to_valid), .sq_to_mask(sq_to_mask),
        .o_uci_ready(o_uci_ready), .o_uci_valid(o_uci_valid),
        .o_uci_data(o_uci_data), .o_uci_sop(o_uci_sop), .o_uci_eop(o_uci_eop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          bpiece[64];
    bit          bwhite[64];
    logic [63:0] masks[64];
    logic [19:0] exp_w[$];
    logic [19:0] got_w[$];
    int          exp_from[$];
    bit          got_sop[$];
    bit          got_eop[$];
    int          nreq;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic void clear_board();
        for (int s = 0; s < 64; s++) begin
            bpiece[s] = 0;
            bwhite[s] = 1'b0;
            masks[s]  = '0;
        end
    endfunction

    // Board-level model: side's pieces in bus order, truncated to the stack
    // depth; each set mask bit ascending is one move, four on promotion.
    function automatic void build_exp(input bit wtp);
        int n;
        int reps;
        n = 0;
        exp_w.delete();
        exp_from.delete();
        for (int k = 0; k < 64; k++) begin
            int s;
            s = (7 - k / 8) * 8 + k % 8;
            if (bpiece[s] != 0 && bwhite[s] == wtp && n < TB_DEPTH) begin
                exp_from.push_back(s);
                n++;
            end
        end
        foreach (exp_from[j]) begin
            int s;
            s = exp_from[j];
            for (int t = 0; t < 64; t++) begin
                if (masks[s][t]) begin
                    reps = (TB_PX && bpiece[s] == 6 &&
                            t / 8 == (wtp ? 7 : 0)) ? 4 : 1;
                    for (int p = 0; p < reps; p++)
                        exp_w.push_back({2'(p), 3'(bpiece[s]), 3'(s / 8),
                                         3'(s % 8), 3'(bpiece[t]),
                                         3'(t / 8), 3'(t % 8)});
                end
            end
        end
        exp_w.push_back(20'd0);
    endfunction

    task automatic load_board();
        int nw;
        int nb;
        nw = 0;
        nb = 0;
        for (int k = 0; k < 64; k++) begin
            int s;
            s = (7 - k / 8) * 8 + k % 8;
            if (bpiece[s] != 0) begin
                if (bwhite[s]) nw++;
                else nb++;
            end
            in_pos_valid = 1'b1;
            in_pos_sop   = (k == 0);
            in_pos_eop   = (k == 63);
            in_pos_data  = {bwhite[s], 3'(bpiece[s])};
            @(negedge clk);
        end
        in_pos_valid = 1'b0;
        in_pos_sop   = 1'b0;
        in_pos_eop   = 1'b0;
        chk("overflow", overflow, (nw > TB_DEPTH) || (nb > TB_DEPTH));
    endtask

    task automatic run_frame(input bit wtp, input int rdy_pct,
                             input int stall_at);
        int          cyc;
        int          resp;
        int          stall;
        bit          done;
        bit          held;
        bit          stall_used;
        logic [21:0] prev;
        logic [5:0]  req_sq;
        build_exp(wtp);
        got_w.delete();
        got_sop.delete();
        got_eop.delete();
        nreq   = 0;
        in_wtp = wtp;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        in_wtp = ~wtp;
        chk("busy_on", busy, 1);
        cyc = 0; resp = 0; stall = 0; done = 0; held = 0;
        stall_used = 0; prev = '0; req_sq = '0;
        while (!done && cyc < 4000) begin
            sq_to_valid = 1'b0;
            sq_to_mask  = {$urandom, $urandom};
            if (resp > 0) begin
                resp--;
                if (resp == 0) begin
                    sq_to_valid = 1'b1;
                    sq_to_mask  = masks[req_sq];
                end
            end
            if (sq_from_valid) begin
                chk("sq_from", sq_from,
                    nreq < exp_from.size() ? exp_from[nreq] : 64);
                nreq++;
                req_sq = sq_from;
                resp   = $urandom_range(1, 3);
            end
            if (held)
                chk("stall_hold",
                    {o_uci_valid, o_uci_sop, o_uci_eop, o_uci_data},
                    {1'b1, prev});
            start        = ($urandom_range(0, 7) == 0);
            in_pos_valid = ($urandom_range(0, 3) == 0);
            in_pos_sop   = 1'($urandom);
            in_pos_data  = 4'($urandom);
            if (stall > 0) begin
                o_uci_ready = 1'b0;
                stall--;
            end else if (!stall_used && o_uci_valid &&
                         got_w.size() == stall_at) begin
                o_uci_ready = 1'b0;
                stall       = 4;
                stall_used  = 1'b1;
            end else begin
                o_uci_ready = ($urandom_range(0, 99) < rdy_pct);
            end
            if (o_uci_valid && o_uci_ready) begin
                got_w.push_back(o_uci_data);
                got_sop.push_back(o_uci_sop);
                got_eop.push_back(o_uci_eop);
                if (o_uci_eop) done = 1'b1;
            end
            held = o_uci_valid && !o_uci_ready;
            prev = {o_uci_sop, o_uci_eop, o_uci_data};
            @(negedge clk);
            cyc++;
        end
        start        = 1'b0;
        in_pos_valid = 1'b0;
        in_pos_sop   = 1'b0;
        o_uci_ready  = 1'b0;
        sq_to_valid  = 1'b0;
        chk("frame_done", done, 1);
        chk("busy_off", busy, 0);
        chk("nreq", nreq, exp_from.size());
        chk("nwords", got_w.size(), exp_w.size());
        foreach (got_w[i]) begin
            if (i < exp_w.size()) chk("word", got_w[i], exp_w[i]);
            chk("sop", got_sop[i], i == 0);
            chk("eop", got_eop[i], i == exp_w.size() - 1);
        end
    endtask

    initial begin
        rst_n = 1'b0; in_pos_valid = 1'b0; in_pos_data = '0;
        in_pos_sop = 1'b0; in_pos_eop = 1'b0; in_wtp = 1'b0;
        start = 1'b0; sq_to_valid = 1'b0; sq_to_mask = '0;
        o_uci_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", o_uci_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_req", sq_from_valid, 0);
        chk("rst_out", {o_uci_sop, o_uci_eop, o_uci_data}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Lone white king on e1
        clear_board();
        bpiece[4] = 1; bwhite[4] = 1'b1;
        masks[4] = (64'd1 << 3) | (64'd1 << 5) | (64'd1 << 11) |
                   (64'd1 << 12) | (64'd1 << 13);
        load_board();
        run_frame(1'b1, 100, 2);
        if (got_w.size() > 0)
            chk("ke1_first", got_w[0],
                {2'd0, 3'd1, 3'd0, 3'd4, 3'd0, 3'd0, 3'd3});

        // Only black pieces, white to play
        clear_board();
        bpiece[59] = 2; masks[59] = 64'hff;
        bpiece[62] = 5; masks[62] = 64'hf0;
        load_board();
        run_frame(1'b1, 80, -1);

        // White pieces whose masks are all empty
        clear_board();
        bpiece[0] = 3; bwhite[0] = 1'b1;
        bpiece[9] = 6; bwhite[9] = 1'b1;
        load_board();
        run_frame(1'b1, 100, -1);

        // Promotion on a8 and capture-promotion on b8
        clear_board();
        bpiece[48] = 6; bwhite[48] = 1'b1;
        bpiece[57] = 3;
        masks[48] = (64'd1 << 56) | (64'd1 << 57);
        load_board();
        run_frame(1'b1, 100, -1);
        if (got_w.size() > 4) begin
            chk("promo3", got_w[3], {2'd3, 3'd6, 3'd6, 3'd0, 3'd0, 3'd7, 3'd0});
            chk("promo_take", got_w[4], {2'd0, 3'd6, 3'd6, 3'd0, 3'd3, 3'd7, 3'd1});
        end

        // Six white pawns against a four-deep stack
        clear_board();
        for (int f = 0; f < 6; f++) begin
            bpiece[8 + f] = 6; bwhite[8 + f] = 1'b1;
            masks[8 + f] = (64'd1 << (16 + f)) | (64'd1 << (24 + f));
        end
        bpiece[20] = 4;
        load_board();
        run_frame(1'b1, 70, 3);

        // Random positions, random side
        for (int r = 0; r < 8; r++) begin
            clear_board();
            for (int s = 0; s < 64; s++) begin
                if ($urandom_range(0, 99) < 9) begin
                    bpiece[s] = $urandom_range(1, 6);
                    bwhite[s] = 1'($urandom);
                end
                masks[s] = ($urandom_range(0, 3) == 0) ? 64'd0 :
                           ({$urandom, $urandom} & {$urandom, $urandom} &
                            {$urandom, $urandom});
            end
            load_board();
            run_frame(1'($urandom), 60, $urandom_range(0, 4));
        end

        // Reset while a word is pending
        clear_board();
        bpiece[4] = 1; bwhite[4] = 1'b1;
        masks[4] = (64'd1 << 3) | (64'd1 << 12);
        load_board();
        in_wtp = 1'b1; start = 1'b1; o_uci_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20 && !sq_from_valid; i++) @(negedge clk);
        chk("mid_req", sq_from_valid, 1);
        @(negedge clk);
        sq_to_valid = 1'b1; sq_to_mask = masks[4];
        @(negedge clk);
        sq_to_valid = 1'b0;
        for (int i = 0; i < 20 && !o_uci_valid; i++) @(negedge clk);
        chk("mid_emit", o_uci_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", o_uci_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_eop", o_uci_eop, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        load_board();
        run_frame(1'b1, 90, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
